// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the ULA issue path.
//   - 4-bit ULA OP codes (including ILLEGAL_OP, for which the ULA returns 0)
//   - instruction opcode[31:26] and funct[5:0] values recognised by ula_decode
//   - sext16: sign-extends a 16-bit immediate to 32 bits
package ula_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_XOR     = 4'b0011;
    localparam logic [3:0] OP_NOR     = 4'b0100;
    localparam logic [3:0] OP_ADD     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SLTU    = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_SLL     = 4'b1001;
    localparam logic [3:0] OP_SRL     = 4'b1010;
    localparam logic [3:0] OP_SRA     = 4'b1011;
    localparam logic [3:0] OP_LUI     = 4'b1100;
    localparam logic [3:0] ILLEGAL_OP = 4'b1111;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/ula_decode.sv
// ula_decode: combinational map from decoded-instruction fields and register
// values to the ULA OP code and operand pair, plus branch/illegal flags.
// Optional feature macro: ULA_ISSUE_OVF_EN adds ovf_chk (signed add/sub/addi).
// Ports:
//   opcode, funct, shamt, imm, rs_val, rt_val : instruction fields / operands
//   op, ln1, ln2                              : ULA OP and operands
//   is_branch, branch_ne                      : beq/bne marker and polarity
//   illegal                                   : instruction not recognised
//   ovf_chk (ULA_ISSUE_OVF_EN only)           : overflow is meaningful
module ula_decode
    import ula_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  op,
    output logic [31:0] ln1,
    output logic [31:0] ln2,
    output logic        is_branch,
    output logic        branch_ne,
`ifdef ULA_ISSUE_OVF_EN
    output logic        ovf_chk,
`endif
    output logic        illegal
);

    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] sh_z;
    logic        legal;

    assign imm_s = sext16(imm);
    assign imm_z = {16'b0, imm};
    assign sh_z  = {27'b0, shamt};

    always_comb begin
        op        = ILLEGAL_OP;
        ln1       = '0;
        ln2       = '0;
        is_branch = 1'b0;
        branch_ne = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: begin op = OP_ADD;  ln1 = rs_val; ln2 = rt_val; end
                    FN_SUB, FN_SUBU: begin op = OP_SUB;  ln1 = rs_val; ln2 = rt_val; end
                    FN_AND:          begin op = OP_AND;  ln1 = rs_val; ln2 = rt_val; end
                    FN_OR:           begin op = OP_OR;   ln1 = rs_val; ln2 = rt_val; end
                    FN_XOR:          begin op = OP_XOR;  ln1 = rs_val; ln2 = rt_val; end
                    FN_NOR:          begin op = OP_NOR;  ln1 = rs_val; ln2 = rt_val; end
                    FN_SLT:          begin op = OP_SLT;  ln1 = rs_val; ln2 = rt_val; end
                    FN_SLTU:         begin op = OP_SLTU; ln1 = rs_val; ln2 = rt_val; end
                    // ULA SLL shifts ln2 by ln1, while SRL/SRA shift ln1 by ln2.
                    FN_SLL:          begin op = OP_SLL;  ln1 = sh_z;   ln2 = rt_val; end
                    FN_SRL:          begin op = OP_SRL;  ln1 = rt_val; ln2 = sh_z;   end
                    FN_SRA:          begin op = OP_SRA;  ln1 = rt_val; ln2 = sh_z;   end
                    FN_SLLV:         begin op = OP_SLL;  ln1 = rs_val; ln2 = rt_val; end
                    FN_SRLV:         begin op = OP_SRL;  ln1 = rt_val; ln2 = rs_val; end
                    FN_SRAV:         begin op = OP_SRA;  ln1 = rt_val; ln2 = rs_val; end
                    default:         legal = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_ADDIU,
            OPC_LW, OPC_SW:  begin op = OP_ADD;  ln1 = rs_val; ln2 = imm_s; end
            OPC_SLTI:        begin op = OP_SLT;  ln1 = rs_val; ln2 = imm_s; end
            OPC_SLTIU:       begin op = OP_SLTU; ln1 = rs_val; ln2 = imm_s; end
            OPC_ANDI:        begin op = OP_AND;  ln1 = rs_val; ln2 = imm_z; end
            OPC_ORI:         begin op = OP_OR;   ln1 = rs_val; ln2 = imm_z; end
            OPC_XORI:        begin op = OP_XOR;  ln1 = rs_val; ln2 = imm_z; end
            OPC_LUI:         begin op = OP_LUI;  ln1 = imm_z;  ln2 = '0;    end
            OPC_BEQ, OPC_BNE: begin
                op        = OP_SUB;
                ln1       = rs_val;
                ln2       = rt_val;
                is_branch = 1'b1;
                branch_ne = (opcode == OPC_BNE);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op  = ILLEGAL_OP;
            ln1 = '0;
            ln2 = '0;
        end
        illegal = !legal;
    end

`ifdef ULA_ISSUE_OVF_EN
    // Only the trapping forms; addu/subu/addiu wrap silently.
    assign ovf_chk = ((opcode == OPC_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)))
                   || (opcode == OPC_ADDI);
`endif

endmodule

// File: rtl/ula_issue.sv
// ula_issue: two-stage initiator for the ULA operation interface.
//   S1 registers the decoded OP/operands and drives the ULA directly.
//   S2 captures the ULA result/Zero_flag and presents it downstream.
// Optional feature macro: ULA_ISSUE_OVF_EN adds out_overflow (signed add/sub/addi).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready, in_*         : instruction fields, operands, dest tag
//   alu_op/alu_ln1/alu_ln2          : ULA request (from S1 registers)
//   alu_result/alu_zero             : ULA combinational return
//   out_valid/out_ready, out_*      : result, tag, branch decision, illegal flag
module ula_issue
    import ula_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_ln1,
    output logic [31:0]      alu_ln2,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_branch_taken,
`ifdef ULA_ISSUE_OVF_EN
    output logic             out_overflow,
`endif
    output logic             out_illegal
);

    logic [3:0]       dec_op;
    logic [31:0]      dec_ln1;
    logic [31:0]      dec_ln2;
    logic             dec_is_branch;
    logic             dec_branch_ne;
    logic             dec_illegal;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [31:0]      s1_ln1;
    logic [31:0]      s1_ln2;
    logic             s1_is_branch;
    logic             s1_branch_ne;
    logic             s1_illegal;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_free;

`ifdef ULA_ISSUE_OVF_EN
    logic dec_ovf_chk;
    logic s1_ovf_chk;
    logic ovf_raw;
`endif

    ula_decode u_decode (
        .opcode    (in_opcode),
        .funct     (in_funct),
        .shamt     (in_shamt),
        .imm       (in_imm),
        .rs_val    (in_rs_val),
        .rt_val    (in_rt_val),
        .op        (dec_op),
        .ln1       (dec_ln1),
        .ln2       (dec_ln2),
        .is_branch (dec_is_branch),
        .branch_ne (dec_branch_ne),
`ifdef ULA_ISSUE_OVF_EN
        .ovf_chk   (dec_ovf_chk),
`endif
        .illegal   (dec_illegal)
    );

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    assign alu_op  = s1_op;
    assign alu_ln1 = s1_ln1;
    assign alu_ln2 = s1_ln2;

    // When in_ready is high, whatever sits in S1 moves to S2 this edge, so S1
    // simply takes the new request (or empties).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_op        <= ILLEGAL_OP;
            s1_ln1       <= '0;
            s1_ln2       <= '0;
            s1_is_branch <= 1'b0;
            s1_branch_ne <= 1'b0;
            s1_illegal   <= 1'b0;
            s1_tag       <= '0;
`ifdef ULA_ISSUE_OVF_EN
            s1_ovf_chk   <= 1'b0;
`endif
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op        <= dec_op;
                s1_ln1       <= dec_ln1;
                s1_ln2       <= dec_ln2;
                s1_is_branch <= dec_is_branch;
                s1_branch_ne <= dec_branch_ne;
                s1_illegal   <= dec_illegal;
                s1_tag       <= in_tag;
`ifdef ULA_ISSUE_OVF_EN
                s1_ovf_chk   <= dec_ovf_chk;
`endif
            end
        end
    end

`ifdef ULA_ISSUE_OVF_EN
    always_comb begin
        ovf_raw = 1'b0;
        if (s1_op == OP_SUB)
            ovf_raw = (s1_ln1[31] != s1_ln2[31]) && (alu_result[31] != s1_ln1[31]);
        else
            ovf_raw = (s1_ln1[31] == s1_ln2[31]) && (alu_result[31] != s1_ln1[31]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_tag          <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
`ifdef ULA_ISSUE_OVF_EN
            out_overflow     <= 1'b0;
`endif
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                // Force 0 for illegal ops rather than trusting the ULA's reply.
                out_result       <= s1_illegal ? '0 : alu_result;
                out_tag          <= s1_tag;
                out_branch_taken <= s1_is_branch && (alu_zero ^ s1_branch_ne);
                out_illegal      <= s1_illegal;
`ifdef ULA_ISSUE_OVF_EN
                out_overflow     <= s1_ovf_chk && ovf_raw;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_issue.sv
module tb_ula_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [4:0]  in_tag;
    logic [3:0]  alu_op;
    logic [31:0] alu_ln1;
    logic [31:0] alu_ln2;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_branch_taken;
    logic        out_illegal;
`ifdef ULA_ISSUE_OVF_EN
    logic        out_overflow;
`endif

    int n_checks;
    int n_fail;

    ula_issue #(.TAG_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_opcode        (in_opcode),
        .in_funct         (in_funct),
        .in_shamt         (in_shamt),
        .in_imm           (in_imm),
        .in_rs_val        (in_rs_val),
        .in_rt_val        (in_rt_val),
        .in_tag           (in_tag),
        .alu_op           (alu_op),
        .alu_ln1          (alu_ln1),
        .alu_ln2          (alu_ln2),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_tag          (out_tag),
        .out_branch_taken (out_branch_taken),
`ifdef ULA_ISSUE_OVF_EN
        .out_overflow     (out_overflow),
`endif
        .out_illegal      (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA responder.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'b0000: alu_result = alu_ln1 & alu_ln2;
            4'b0001: alu_result = alu_ln1 | alu_ln2;
            4'b0011: alu_result = alu_ln1 ^ alu_ln2;
            4'b0100: alu_result = ~(alu_ln1 | alu_ln2);
            4'b0101: alu_result = alu_ln1 + alu_ln2;
            4'b0110: alu_result = alu_ln1 - alu_ln2;
            4'b0111: alu_result = {31'b0, (alu_ln1 < alu_ln2)};
            4'b1000: alu_result = {31'b0, ($signed(alu_ln1) < $signed(alu_ln2))};
            4'b1001: alu_result = alu_ln2 << alu_ln1[4:0];
            4'b1010: alu_result = alu_ln1 >> alu_ln2[4:0];
            4'b1011: alu_result = $unsigned($signed(alu_ln1) >>> alu_ln2[4:0]);
            4'b1100: alu_result = alu_ln1 << 16;
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] tag);
        in_opcode = opc; in_funct = fn; in_shamt = sh; in_imm = imm;
        in_rs_val = rs;  in_rt_val = rt; in_tag = tag; in_valid = 1'b1;
    endtask

    // Called at a negedge with the pipeline able to accept; returns just after the accept edge.
    task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] tag);
        drive(opc, fn, sh, imm, rs, rt, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(6'h0, 6'h0, 5'h0, 16'h0, 32'h0, 32'h0, 5'h0); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (alu_op !== 4'b1111) begin n_fail++; $display("FAIL reset_alu_op got %b exp 1111", alu_op); end
        n_checks++; if (alu_ln1 !== 32'h0 || alu_ln2 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_ln got %h/%h exp 0/0", alu_ln1, alu_ln2); end
        n_checks++; if (out_result !== 32'h0 || out_tag !== 5'h0 || out_branch_taken !== 1'b0 || out_illegal !== 1'b0)
            begin n_fail++; $display("FAIL reset_out_data got res=%h tag=%h br=%b ill=%b exp all 0", out_result, out_tag, out_branch_taken, out_illegal); end
`ifdef ULA_ISSUE_OVF_EN
        n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", out_overflow); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        issue(6'b000000, 6'b100000, 5'd0, 16'h0, 32'd5, 32'd7, 5'd3);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b0101) begin n_fail++; $display("FAIL add_op got %b exp 0101", alu_op); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early got %b exp 0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", out_valid); end
        n_checks++; if (out_result !== 32'd12 || out_tag !== 5'd3) begin n_fail++; $display("FAIL add_result got %0d tag %0d exp 12 tag 3", out_result, out_tag); end
        n_checks++; if (out_branch_taken !== 1'b0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL add_flags got br=%b ill=%b exp 0/0", out_branch_taken, out_illegal); end
    endtask

    task automatic test_shifts;
        issue(6'b000000, 6'b000000, 5'd4, 16'h0, 32'h0, 32'h1, 5'd1);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1001 || alu_ln1 !== 32'd4 || alu_ln2 !== 32'd1)
            begin n_fail++; $display("FAIL sll_operands got op=%b ln1=%h ln2=%h exp 1001/4/1", alu_op, alu_ln1, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_result !== 32'h10) begin n_fail++; $display("FAIL sll_result got %h exp 00000010", out_result); end
        issue(6'b000000, 6'b000011, 5'd4, 16'h0, 32'h0, 32'h8000_0000, 5'd2);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1011 || alu_ln1 !== 32'h8000_0000 || alu_ln2 !== 32'd4)
            begin n_fail++; $display("FAIL sra_operands got op=%b ln1=%h ln2=%h exp 1011/80000000/4", alu_op, alu_ln1, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_result !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_result got %h exp f8000000", out_result); end
        issue(6'b000000, 6'b000110, 5'd0, 16'h0, 32'd4, 32'h100, 5'd2);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1010 || alu_ln1 !== 32'h100 || alu_ln2 !== 32'd4)
            begin n_fail++; $display("FAIL srlv_operands got op=%b ln1=%h ln2=%h exp 1010/100/4", alu_op, alu_ln1, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_result !== 32'h10) begin n_fail++; $display("FAIL srlv_result got %h exp 00000010", out_result); end
    endtask

    task automatic test_branch_imm;
        issue(6'b000100, 6'b000000, 5'd0, 16'h0, 32'd9, 32'd9, 5'd0);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_branch_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken got %b exp 1", out_branch_taken); end
        issue(6'b000101, 6'b000000, 5'd0, 16'h0, 32'd9, 32'd9, 5'd0);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_branch_taken !== 1'b0) begin n_fail++; $display("FAIL bne_taken got %b exp 0", out_branch_taken); end
        issue(6'b001010, 6'b000000, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'h0, 5'd7);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1000 || alu_ln2 !== 32'd1) begin n_fail++; $display("FAIL slti_operands got op=%b ln2=%h exp 1000/1", alu_op, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_result !== 32'd1 || out_tag !== 5'd7) begin n_fail++; $display("FAIL slti_result got %h tag %0d exp 1 tag 7", out_result, out_tag); end
        issue(6'b001101, 6'b000000, 5'd0, 16'h8000, 32'h0, 32'h0, 5'd8);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_result !== 32'h0000_8000) begin n_fail++; $display("FAIL ori_zext got %h exp 00008000", out_result); end
        issue(6'b001111, 6'b000000, 5'd0, 16'h1234, 32'hFFFF, 32'h0, 5'd9);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1100 || alu_ln1 !== 32'h1234 || alu_ln2 !== 32'h0)
            begin n_fail++; $display("FAIL lui_operands got op=%b ln1=%h ln2=%h exp 1100/1234/0", alu_op, alu_ln1, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_result !== 32'h1234_0000) begin n_fail++; $display("FAIL lui_result got %h exp 12340000", out_result); end
    endtask

    task automatic test_back_to_back;
        drive(6'b001000, 6'h0, 5'd0, 16'd1, 32'd10, 32'h0, 5'd4);
        @(posedge clk); @(negedge clk);
        drive(6'b001101, 6'h0, 5'd0, 16'h00F0, 32'h0, 32'h0, 5'd5);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd4 || out_result !== 32'd11)
            begin n_fail++; $display("FAIL b2b_first got v=%b tag=%0d res=%0d exp 1/4/11", out_valid, out_tag, out_result); end
        drive(6'b000000, 6'b100010, 5'd0, 16'h0, 32'd20, 32'd5, 5'd6);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd5 || out_result !== 32'h00F0)
            begin n_fail++; $display("FAIL b2b_second got v=%b tag=%0d res=%h exp 1/5/f0", out_valid, out_tag, out_result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd6 || out_result !== 32'd15)
            begin n_fail++; $display("FAIL b2b_third got v=%b tag=%0d res=%0d exp 1/6/15", out_valid, out_tag, out_result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(6'b001000, 6'h0, 5'd0, 16'd1, 32'd1, 32'h0, 5'd1);
        @(posedge clk); @(negedge clk);
        drive(6'b001000, 6'h0, 5'd0, 16'd2, 32'd1, 32'h0, 5'd2);
        @(posedge clk); @(negedge clk);
        drive(6'b001000, 6'h0, 5'd0, 16'd3, 32'd1, 32'h0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_result !== 32'd2)
                begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b tag=%0d res=%0d exp 1/1/2", i, out_valid, out_tag, out_result); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_result !== 32'd3)
            begin n_fail++; $display("FAIL bp_second got v=%b tag=%0d res=%0d exp 1/2/3", out_valid, out_tag, out_result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_result !== 32'd4)
            begin n_fail++; $display("FAIL bp_third got v=%b tag=%0d res=%0d exp 1/3/4", out_valid, out_tag, out_result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal;
        issue(6'b111111, 6'h0, 5'd0, 16'hFFFF, 32'd5, 32'd6, 5'd10);
        @(negedge clk);
        n_checks++; if (alu_op !== 4'b1111 || alu_ln1 !== 32'h0 || alu_ln2 !== 32'h0)
            begin n_fail++; $display("FAIL illegal_operands got op=%b ln1=%h ln2=%h exp 1111/0/0", alu_op, alu_ln1, alu_ln2); end
        @(negedge clk);
        n_checks++; if (out_illegal !== 1'b1 || out_result !== 32'h0 || out_branch_taken !== 1'b0 || out_tag !== 5'd10)
            begin n_fail++; $display("FAIL illegal_out got ill=%b res=%h br=%b tag=%0d exp 1/0/0/10", out_illegal, out_result, out_branch_taken, out_tag); end
        issue(6'b000000, 6'b001000, 5'd0, 16'h0, 32'd5, 32'd6, 5'd11);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_illegal !== 1'b1 || out_result !== 32'h0)
            begin n_fail++; $display("FAIL illegal_funct got ill=%b res=%h exp 1/0", out_illegal, out_result); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(6'b001000, 6'h0, 5'd0, 16'd1, 32'd1, 32'h0, 5'd1);
        @(posedge clk); @(negedge clk);
        drive(6'b001000, 6'h0, 5'd0, 16'd2, 32'd1, 32'h0, 5'd2);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_op !== 4'b1111 || out_result !== 32'h0)
            begin n_fail++; $display("FAIL rstmid_clear got v=%b rdy=%b op=%b res=%h exp 0/1/1111/0", out_valid, in_ready, alu_op, out_result); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d] got %b exp 0", i, out_valid); end
        end
    endtask

`ifdef ULA_ISSUE_OVF_EN
    task automatic test_overflow;
        issue(6'b000000, 6'b100000, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 5'd1);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_overflow !== 1'b1 || out_result !== 32'h8000_0000)
            begin n_fail++; $display("FAIL ovf_add got ovf=%b res=%h exp 1/80000000", out_overflow, out_result); end
        issue(6'b000000, 6'b100001, 5'd0, 16'h0, 32'h7FFF_FFFF, 32'h1, 5'd2);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_overflow !== 1'b0 || out_result !== 32'h8000_0000)
            begin n_fail++; $display("FAIL ovf_addu got ovf=%b res=%h exp 0/80000000", out_overflow, out_result); end
        issue(6'b000000, 6'b100010, 5'd0, 16'h0, 32'h8000_0000, 32'h1, 5'd3);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_overflow !== 1'b1 || out_result !== 32'h7FFF_FFFF)
            begin n_fail++; $display("FAIL ovf_sub got ovf=%b res=%h exp 1/7fffffff", out_overflow, out_result); end
        issue(6'b001000, 6'h0, 5'd0, 16'h0001, 32'h7FFF_FFFF, 32'h0, 5'd4);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_addi got %b exp 1", out_overflow); end
        issue(6'b000000, 6'b100000, 5'd0, 16'h0, 32'd5, 32'd7, 5'd5);
        @(negedge clk); @(negedge clk);
        n_checks++; if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_none got %b exp 0", out_overflow); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_add;
        test_shifts;
        test_branch_imm;
        test_back_to_back;
        test_backpressure;
        test_illegal;
        test_reset_mid;
`ifdef ULA_ISSUE_OVF_EN
        test_overflow;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
